// File: rtl/round_controller.sv
// round_controller
//   Game sequencer sitting between the comparator and the random number
//   generator / display. Runs the round timer, keeps a BCD score and asks the
//   random generator for a fresh number with a one-cycle pulse.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-low reset
//   start      in   one-cycle start pulse (IDLE / OVER only)
//   tick       in   one-cycle 1 Hz enable
//   is_equal   in   comparator match level
//   new_num    out  one-cycle request for a new random number
//   score      out  BCD score [7:4] tens, [3:0] units, saturates at 99
//   time_left  out  BCD seconds remaining
//   state      out  00 IDLE, 01 PLAY, 10 WAIT_CLEAR, 11 OVER
//   game_over  out  high while in OVER
module round_controller #(
  parameter int unsigned ROUND_TIME = 10,
  parameter int unsigned MATCH_HOLD = 4,
  parameter int unsigned CLEAR_TO   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tick,
  input  logic       is_equal,
  output logic       new_num,
  output logic [7:0] score,
  output logic [7:0] time_left,
  output logic [1:0] state,
  output logic       game_over
);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    PLAY       = 2'b01,
    WAIT_CLEAR = 2'b10,
    OVER       = 2'b11
  } state_t;

  localparam logic [7:0] TIME_INIT  = {4'(ROUND_TIME / 10), 4'(ROUND_TIME % 10)};
  localparam logic [7:0] HOLD_LAST  = 8'(MATCH_HOLD - 1);
  localparam logic [7:0] CLEAR_LAST = 8'(CLEAR_TO - 1);

  state_t     state_q, state_d;
  logic [7:0] score_q, score_d;
  logic [7:0] time_q, time_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] clr_q, clr_d;
  logic       new_num_q, new_num_d;
  logic       game_over_q, game_over_d;
  logic       expire;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)          r = v;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                     r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h00)          r = v;
    else if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
    else                     r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  // Final tick of the round; only meaningful while the round is running.
  assign expire = tick && (time_q == 8'h01);

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    time_d    = time_q;
    hold_d    = hold_q;
    clr_d     = clr_q;
    new_num_d = 1'b0;

    unique case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d   = PLAY;
          score_d   = '0;
          time_d    = TIME_INIT;
          hold_d    = '0;
          clr_d     = '0;
          new_num_d = 1'b1;
        end
      end

      PLAY: begin
        if (tick) time_d = bcd_dec(time_q);
        if (is_equal) begin
          // The cycle that would bring the counter to MATCH_HOLD qualifies.
          if (hold_q == HOLD_LAST) begin
            score_d   = bcd_inc(score_q);
            hold_d    = '0;
            clr_d     = '0;
            state_d   = WAIT_CLEAR;
            new_num_d = 1'b1;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end else begin
          hold_d = '0;
        end
        // Expiry wins over the state change but keeps a same-cycle score.
        if (expire) begin
          state_d   = OVER;
          new_num_d = 1'b0;
          hold_d    = '0;
        end
      end

      WAIT_CLEAR: begin
        if (tick) time_d = bcd_dec(time_q);
        if (!is_equal) begin
          state_d = PLAY;
          clr_d   = '0;
        end else if (clr_q == CLEAR_LAST) begin
          new_num_d = 1'b1;
          clr_d     = '0;
        end else begin
          clr_d = clr_q + 8'd1;
        end
        if (expire) begin
          state_d   = OVER;
          new_num_d = 1'b0;
          clr_d     = '0;
        end
      end

      default: state_d = IDLE;
    endcase

    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      score_q     <= '0;
      time_q      <= TIME_INIT;
      hold_q      <= '0;
      clr_q       <= '0;
      new_num_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      time_q      <= time_d;
      hold_q      <= hold_d;
      clr_q       <= clr_d;
      new_num_q   <= new_num_d;
      game_over_q <= game_over_d;
    end
  end

  assign new_num   = new_num_q;
  assign score     = score_q;
  assign time_left = time_q;
  assign state     = state_q;
  assign game_over = game_over_q;

endmodule
